// File: rtl/rgmii_frame_receiver.sv
// rgmii_frame_receiver
//   Turns DDR-captured RGMII receive bytes into a framed byte stream.
//   Strips preamble/SFD, marks the first and last byte of each frame, flags
//   frames ended by RX_ER or oversize, and decodes in-band link status
//   while the line is idle.
//
// Ports
//   clock               receive clock, rising edge
//   reset               asynchronous active-high reset
//   byte_in[7:0]        [3:0] rising-edge nibble, [7:4] falling-edge nibble
//   control_in[1:0]     [0] RX_DV, [1] RX_DV xor RX_ER
//   packaged_data[9:0]  [7:0] byte, [8] first, [9] last
//   packaged_data_valid one-cycle qualifier for packaged_data
//   packaged_data_error with valid and [9]: frame ended by RX_ER or oversize
//   frame_length[15:0]  emitted byte count, updated with the last byte
//   frame_dropped       pulse when a frame is discarded before any output
//   speed_code[1:0]     in-band speed (00 10M, 01 100M, 10 1000M)
//   link_up             in-band link status
//   full_duplex         in-band duplex status
//
// state      | meaning
// S_IDLE     | line idle, waiting for the first preamble byte
// S_PREAMBLE | counting 0x55 bytes, waiting for SFD
// S_PACK     | frame body; one byte held back so the last can be marked
// S_DROP     | discarding the rest of a bad frame until RX_DV falls

module rgmii_frame_receiver #(
    parameter int PREAMBLE_MIN         = 6,
    parameter int MAX_FRAME_BYTES      = 1522,
    parameter int INBAND_STATUS_ENABLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  control_in,
    output logic [9:0]  packaged_data,
    output logic        packaged_data_valid,
    output logic        packaged_data_error,
    output logic [15:0] frame_length,
    output logic        frame_dropped,
    output logic [1:0]  speed_code,
    output logic        link_up,
    output logic        full_duplex
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PACK     = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    localparam logic [2:0]  PRE_MIN = 3'(PREAMBLE_MIN);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;

    state_t      state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  hold_byte_q, hold_byte_d;
    logic        hold_first_q, hold_first_d;
    logic        first_pend_q, first_pend_d;
    logic [15:0] len_q, len_d;

    logic [9:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic [15:0] flen_q, flen_d;
    logic        dropped_q, dropped_d;
    logic [1:0]  speed_q, speed_d;
    logic        link_q, link_d;
    logic        duplex_q, duplex_d;

    logic dv;
    logic er;

    always_comb begin
        dv = control_in[0];
        er = control_in[0] ^ control_in[1];

        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        hold_valid_d = hold_valid_q;
        hold_byte_d  = hold_byte_q;
        hold_first_d = hold_first_q;
        first_pend_d = first_pend_q;
        len_d        = len_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        error_d      = 1'b0;
        flen_d       = flen_q;
        dropped_d    = 1'b0;
        speed_d      = speed_q;
        link_d       = link_q;
        duplex_d     = duplex_q;

        case (state_q)
            S_IDLE: begin
                if (dv) begin
                    if (byte_in == PRE_BYTE) begin
                        state_d   = S_PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end

            S_PREAMBLE: begin
                if (!dv) begin
                    state_d = S_IDLE;
                end else if (byte_in == PRE_BYTE) begin
                    pre_cnt_d = (pre_cnt_q == 3'd7) ? 3'd7 : pre_cnt_q + 3'd1;
                end else if (byte_in == SFD_BYTE && pre_cnt_q >= PRE_MIN) begin
                    state_d      = S_PACK;
                    first_pend_d = 1'b1;
                    hold_valid_d = 1'b0;
                    len_d        = 16'd0;
                end else begin
                    state_d   = S_DROP;
                    dropped_d = 1'b1;
                end
            end

            S_PACK: begin
                if (!dv || er || len_q == MAX_LEN) begin
                    // Frame ends here: flush the held byte as last, or drop
                    // the frame if nothing was ever captured.
                    if (hold_valid_q) begin
                        valid_d = 1'b1;
                        data_d  = {1'b1, hold_first_q, hold_byte_q};
                        error_d = dv;
                        flen_d  = len_q;
                    end else begin
                        dropped_d = 1'b1;
                    end
                    hold_valid_d = 1'b0;
                    state_d      = dv ? S_DROP : S_IDLE;
                end else begin
                    if (hold_valid_q) begin
                        valid_d = 1'b1;
                        data_d  = {1'b0, hold_first_q, hold_byte_q};
                    end
                    hold_byte_d  = byte_in;
                    hold_first_d = first_pend_q;
                    first_pend_d = 1'b0;
                    hold_valid_d = 1'b1;
                    len_d        = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                end
            end

            S_DROP: begin
                if (!dv) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // In-band status is repeated in both nibbles while the line is idle.
        if (INBAND_STATUS_ENABLE != 0 && !dv && !er && byte_in[3:0] == byte_in[7:4]) begin
            link_d   = byte_in[0];
            speed_d  = byte_in[2:1];
            duplex_d = byte_in[3];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pre_cnt_q    <= 3'd0;
            hold_valid_q <= 1'b0;
            hold_byte_q  <= 8'd0;
            hold_first_q <= 1'b0;
            first_pend_q <= 1'b0;
            len_q        <= 16'd0;
            data_q       <= 10'd0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            flen_q       <= 16'd0;
            dropped_q    <= 1'b0;
            speed_q      <= 2'd0;
            link_q       <= 1'b0;
            duplex_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_byte_q  <= hold_byte_d;
            hold_first_q <= hold_first_d;
            first_pend_q <= first_pend_d;
            len_q        <= len_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
            flen_q       <= flen_d;
            dropped_q    <= dropped_d;
            speed_q      <= speed_d;
            link_q       <= link_d;
            duplex_q     <= duplex_d;
        end
    end

    assign packaged_data       = data_q;
    assign packaged_data_valid = valid_q;
    assign packaged_data_error = error_q;
    assign frame_length        = flen_q;
    assign frame_dropped       = dropped_q;
    assign speed_code          = speed_q;
    assign link_up             = link_q;
    assign full_duplex         = duplex_q;

endmodule

// File: tb/tb_rgmii_frame_receiver.sv
module tb_rgmii_frame_receiver;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic [1:0]  control_in;
    logic [9:0]  packaged_data;
    logic        packaged_data_valid;
    logic        packaged_data_error;
    logic [15:0] frame_length;
    logic        frame_dropped;
    logic [1:0]  speed_code;
    logic        link_up;
    logic        full_duplex;

    rgmii_frame_receiver dut (
        .clock               (clock),
        .reset               (reset),
        .byte_in             (byte_in),
        .control_in          (control_in),
        .packaged_data       (packaged_data),
        .packaged_data_valid (packaged_data_valid),
        .packaged_data_error (packaged_data_error),
        .frame_length        (frame_length),
        .frame_dropped       (frame_dropped),
        .speed_code          (speed_code),
        .link_up             (link_up),
        .full_duplex         (full_duplex)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0]  d;
        logic        e;
        logic [15:0] len;
    } rec_t;

    rec_t q[$];
    int   drops = 0;

    always @(negedge clock) begin
        if (packaged_data_valid) q.push_back('{packaged_data, packaged_data_error, frame_length});
        if (frame_dropped) drops++;
    end

    typedef struct {
        logic [1:0] ctl;
        logic [7:0] b;
        logic       link;
        logic [1:0] spd;
        logic       fd;
    } svec_t;

    svec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] c, input logic [7:0] b);
        @(posedge clock);
        #1;
        control_in = c;
        byte_in    = b;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 8'h00);
    endtask

    task automatic preamble(input int n);
        repeat (n) cyc(2'b11, 8'h55);
        cyc(2'b11, 8'hD5);
    endtask

    task automatic clear();
        idle(4);
        q.delete();
        drops = 0;
    endtask

    // er_at: 1-based index of the byte sent with RX_ER, 0 for none
    task automatic send_frame(input int npre, input int n, input logic [7:0] start, input int er_at);
        logic [7:0] b;
        preamble(npre);
        for (int k = 1; k <= n; k++) begin
            b = start + 8'(k - 1);
            if (k == er_at) cyc(2'b01, b);
            else            cyc(2'b11, b);
        end
        cyc(2'b00, 8'h00);
    endtask

    task automatic check_frame(input string name, input int n, input logic [7:0] start,
                               input logic exp_err, input int exp_drops);
        logic [9:0] exp_d;
        idle(4);
        chk({name, " count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            exp_d = {(i == n - 1), (i == 0), start + 8'(i)};
            chk({name, " data"}, q[i].d, exp_d);
        end
        if (n > 0 && q.size() == n) begin
            chk({name, " err"}, q[n-1].e, exp_err);
            chk({name, " len"}, q[n-1].len, n);
        end
        chk({name, " drops"}, drops, exp_drops);
    endtask

    initial begin
        tv[0] = '{2'b00, 8'hDD, 1'b1, 2'b10, 1'b1};
        tv[1] = '{2'b00, 8'hD5, 1'b1, 2'b10, 1'b1};
        tv[2] = '{2'b00, 8'h00, 1'b0, 2'b00, 1'b0};
        tv[3] = '{2'b00, 8'h33, 1'b1, 2'b01, 1'b0};
        tv[4] = '{2'b11, 8'hDD, 1'b1, 2'b01, 1'b0};
        tv[5] = '{2'b10, 8'hDD, 1'b1, 2'b01, 1'b0};
        tv[6] = '{2'b00, 8'h99, 1'b1, 2'b00, 1'b1};
        tv[7] = '{2'b00, 8'hDD, 1'b1, 2'b10, 1'b1};

        reset      = 1'b1;
        control_in = 2'b00;
        byte_in    = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst data",    packaged_data, 10'd0);
        chk("rst valid",   packaged_data_valid, 1'b0);
        chk("rst err",     packaged_data_error, 1'b0);
        chk("rst len",     frame_length, 16'd0);
        chk("rst dropped", frame_dropped, 1'b0);
        chk("rst status",  {link_up, speed_code, full_duplex}, 4'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // two-cycle latency of a non-final byte
        clear();
        preamble(7);
        cyc(2'b11, 8'h5A);
        cyc(2'b11, 8'h5B);
        @(negedge clock);
        chk("lat early valid", packaged_data_valid, 1'b0);
        cyc(2'b00, 8'h00);
        @(negedge clock);
        chk("lat valid", packaged_data_valid, 1'b1);
        chk("lat data",  packaged_data, 10'h15A);
        check_frame("lat", 2, 8'h5A, 1'b0, 0);

        clear();
        send_frame(7, 64, 8'h01, 0);
        check_frame("f64", 64, 8'h01, 1'b0, 0);

        // single byte, preamble exactly at the minimum
        clear();
        send_frame(6, 1, 8'hAB, 0);
        check_frame("single", 1, 8'hAB, 1'b0, 0);

        // short preamble; the later good-looking preamble must stay dropped
        clear();
        repeat (3) cyc(2'b11, 8'h55);
        cyc(2'b11, 8'hD5);
        repeat (8) cyc(2'b11, 8'h55);
        cyc(2'b11, 8'hD5);
        cyc(2'b11, 8'h11);
        cyc(2'b11, 8'h22);
        cyc(2'b00, 8'h00);
        check_frame("short_pre", 0, 8'h00, 1'b0, 1);

        clear();
        send_frame(5, 4, 8'h10, 0);
        check_frame("pre5", 0, 8'h00, 1'b0, 1);

        clear();
        send_frame(7, 10, 8'h30, 6);
        check_frame("er6", 5, 8'h30, 1'b1, 0);

        clear();
        send_frame(7, 0, 8'h00, 0);
        check_frame("empty", 0, 8'h00, 1'b0, 1);

        clear();
        preamble(7);
        cyc(2'b01, 8'h77);
        cyc(2'b11, 8'h78);
        cyc(2'b00, 8'h00);
        check_frame("er_first", 0, 8'h00, 1'b0, 1);

        clear();
        cyc(2'b11, 8'h55);
        cyc(2'b11, 8'h55);
        cyc(2'b00, 8'h00);
        check_frame("pre_abort", 0, 8'h00, 1'b0, 0);

        clear();
        cyc(2'b11, 8'h12);
        preamble(7);
        cyc(2'b11, 8'h01);
        cyc(2'b11, 8'h02);
        cyc(2'b00, 8'h00);
        check_frame("bad_start", 0, 8'h00, 1'b0, 0);

        clear();
        send_frame(7, 1600, 8'h01, 0);
        check_frame("oversize", 1522, 8'h01, 1'b1, 0);

        // reset in the middle of a frame, then resynchronise
        clear();
        preamble(7);
        for (int k = 0; k < 5; k++) cyc(2'b11, 8'(8'h80 + k));
        @(posedge clock);
        @(negedge clock);
        #1;
        q.delete();
        reset = 1'b1;
        @(negedge clock);
        chk("midrst valid", packaged_data_valid, 1'b0);
        chk("midrst data",  packaged_data, 10'd0);
        chk("midrst len",   frame_length, 16'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        cyc(2'b11, 8'h86);
        cyc(2'b11, 8'h87);
        idle(4);
        chk("midrst no output", q.size(), 0);
        clear();
        send_frame(7, 3, 8'h40, 0);
        check_frame("resync", 3, 8'h40, 1'b0, 0);

        clear();
        for (int i = 0; i < 8; i++) begin
            cyc(tv[i].ctl, tv[i].b);
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("status[%0d] link", i),   link_up,     tv[i].link);
            chk($sformatf("status[%0d] speed", i),  speed_code,  tv[i].spd);
            chk($sformatf("status[%0d] duplex", i), full_duplex, tv[i].fd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgmii_frame_receiver.md
RGMII_FRAME_RECEIVER -- requirements
Module: rgmii_frame_receiver

Interface
REQ-001 SHALL have parameter PREAMBLE_MIN, default 6, minimum count of 0x55 bytes required before SFD (legal range 1..7).
REQ-002 SHALL have parameter MAX_FRAME_BYTES, default 1522, maximum payload bytes after SFD before the frame is declared oversize.
REQ-003 SHALL have parameter INBAND_STATUS_ENABLE, default 1; 1 = decode RGMII in-band link status during idle.
REQ-004 clock  input  1  receive clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 byte_in  input  8  DDR-captured byte, [3:0] = rising-edge nibble, [7:4] = falling-edge nibble.
REQ-007 control_in  input  2  DDR-captured RX_CTL, [0] = rising (RX_DV), [1] = falling (RX_DV xor RX_ER).
REQ-008 packaged_data  output  10  [7:0] byte, [8] first byte of frame, [9] last byte of frame.
REQ-009 packaged_data_valid  output  1  one-cycle qualifier for packaged_data.
REQ-010 packaged_data_error  output  1  meaningful only with valid and [9]; 1 = frame ended by RX_ER or oversize.
REQ-011 frame_length  output  16  byte count of the frame; updated on the cycle last byte is emitted.
REQ-012 frame_dropped  output  1  one-cycle pulse when a frame is discarded before any byte is emitted.
REQ-013 speed_code  output  2  in-band speed: 00 10M, 01 100M, 10 1000M.
REQ-014 link_up  output  1  in-band link status.
REQ-015 full_duplex  output  1  in-band duplex status.

Function
REQ-016 SHALL derive dv = control_in[0], er = control_in[0] xor control_in[1] each cycle.
REQ-017 SHALL implement states S_IDLE, S_PREAMBLE, S_PACK, S_DROP.
REQ-018 S_IDLE: dv and byte 0x55 -> S_PREAMBLE, count=1; dv with any other byte -> S_DROP; else stay.
REQ-019 S_PREAMBLE: dv and 0x55 -> count+1, saturating at 7; dv, 0xD5 and count>=PREAMBLE_MIN -> S_PACK, first flag set, length=0; dv, 0xD5 and count<PREAMBLE_MIN -> S_DROP with frame_dropped pulse; dv with other byte -> S_DROP with pulse; !dv -> S_IDLE, no pulse.
REQ-020 S_PACK SHALL hold one byte in a one-deep skid register so the last byte can be marked; a byte is emitted only when its successor arrives or the frame ends.
REQ-021 S_PACK, dv and !er: if holding, emit held byte with its first flag and [9]=0; capture new byte; length+1.
REQ-022 S_PACK, !dv: if holding, emit held byte with [9]=1, error=0, frame_length=length; -> S_IDLE; if not holding (SFD then immediate end), pulse frame_dropped, no output.
REQ-023 S_PACK, dv and er: if holding, emit held byte with [9]=1, error=1; else pulse frame_dropped; -> S_DROP.
REQ-024 S_PACK, length reaching MAX_FRAME_BYTES with dv still asserted: emit held byte with [9]=1, error=1, frame_length=MAX_FRAME_BYTES; -> S_DROP.
REQ-025 S_DROP: stay until !dv, then -> S_IDLE; no output.
REQ-026 Output latency SHALL be 2 cycles from byte_in to packaged_data for non-final bytes; single-byte frames SHALL carry [8]=1 and [9]=1 together.
REQ-027 First flag SHALL apply only to the first emitted byte of a frame and clear after it.
REQ-028 When INBAND_STATUS_ENABLE=1 and dv=0, er=0, and byte_in[3:0]==byte_in[7:4], SHALL update link_up=byte[0], speed_code=byte[2:1], full_duplex=byte[3]; otherwise hold status.
REQ-029 When INBAND_STATUS_ENABLE=0, status outputs SHALL remain at reset value.
REQ-030 frame_length SHALL count emitted bytes including FCS, saturating at 16'hFFFF.

Reset
REQ-031 On reset: state S_IDLE; all outputs, counters, skid register and flags = 0.
REQ-032 Reset asserted mid-frame SHALL abort without emitting a last byte; after release, the receiver resynchronises on the next preamble.

Verification
REQ-033 7x0x55, 0xD5, bytes 0x01..0x40 (64), dv drop -> 64 valids, first on 0x01, last on 0x40, error=0, frame_length=64.
REQ-034 Preamble 3x0x55 then 0xD5 with PREAMBLE_MIN=6 -> no valid output, frame_dropped pulse, S_DROP until dv=0.
REQ-035 Frame of 10 bytes with er asserted on byte 6 -> bytes 1..5 emitted, byte 5 with [9]=1, error=1; bytes 6..10 discarded.
REQ-036 1600-byte frame, MAX_FRAME_BYTES=1522 -> last at byte 1522, error=1, frame_length=1522, remainder discarded.
REQ-037 Idle with byte_in=0xDD, control_in=00 -> link_up=1, speed_code=10, full_duplex=1; byte_in=0xD5 idle -> status unchanged.
REQ-038 Single-byte frame 0xAB -> one valid with packaged_data=0x3AB, frame_length=1.
